// File: rtl/sc_mul_det.sv
// Deterministic stochastic-computing multiplier: two van der Corput unary streams,
// stream B clock-divided against A, ones counted over a full 2^(2*WIDTH) window.
module sc_mul_det #(
    parameter int WIDTH = 8,
    localparam int ACC_W = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bipolar,
    input  logic             abort,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_count
);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // valid never depends on ready, and the payload is stable while valid is held.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_buf;
    logic [WIDTH-1:0] b_buf;
    logic             mode;
    logic [WIDTH-1:0] cnt_a;
    logic [WIDTH-1:0] cnt_b;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] res_reg;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             sa;
    logic             sb;
    logic             last;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    always_comb begin
        ra      = bitrev(cnt_a);
        rb      = bitrev(cnt_b);
        sa      = (a_buf > ra);
        sb      = (b_buf > rb);
        last    = (cnt_a == '1) && (cnt_b == '1);
        bit_out = 1'b0;
        if (state == RUN) bit_out = mode ? ~(sa ^ sb) : (sa & sb);
    end

    assign in_ready  = (state == IDLE);
    assign bit_valid = (state == RUN);
    assign res_valid = (state == DONE);
    assign res_count = res_reg;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN: begin
                // abort outranks completion on the final window cycle
                if (abort)     state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_buf   <= '0;
            b_buf   <= '0;
            mode    <= 1'b0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            acc     <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_buf <= in_a;
                        b_buf <= in_b;
                        mode  <= in_bipolar;
                        cnt_a <= '0;
                        cnt_b <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        cnt_a <= '0;
                        cnt_b <= '0;
                        acc   <= '0;
                    end else begin
                        acc   <= acc + ACC_W'(bit_out);
                        cnt_a <= cnt_a + 1'b1;
                        cnt_b <= cnt_b + WIDTH'(cnt_a == '1);
                        if (last) res_reg <= acc + ACC_W'(bit_out);
                    end
                end
                DONE: begin
                    // result reads as zero outside DONE
                    if (res_ready) res_reg <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_mul_det.sv
// Bench for sc_mul_det at WIDTH=4: directed cases plus random operand pairs,
// checked against closed-form product formulas.
module tb_sc_mul_det;

    localparam int W = 4;
    localparam int N = 256;
    localparam int AW = 2*W+1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_bipolar;
    logic          abort;
    logic          bit_out;
    logic          bit_valid;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_count;

    int n_checks = 0;
    int n_fail   = 0;

    sc_mul_det #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bipolar(in_bipolar), .abort(abort),
        .bit_out(bit_out), .bit_valid(bit_valid), .res_valid(res_valid),
        .res_ready(res_ready), .res_count(res_count)
    );

    always #5 clk = ~clk;

    function automatic int model(input int a, input int b, input bit bip);
        int m;
        m = 1 << W;
        return bip ? (a*b + (m-a)*(m-b)) : a*b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_bit_out"},   bit_out,   0);
        chk({tag, "_bit_valid"}, bit_valid, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_count"}, res_count, 0);
    endtask

    // Offer a pair on a negedge; the next posedge is the accept edge.
    task automatic offer(input int a, input int b, input bit bip);
        in_valid   = 1'b1;
        in_a       = W'(a);
        in_b       = W'(b);
        in_bipolar = bip;
        @(negedge clk);
        in_valid   = 1'b0;
        in_a       = W'($urandom);
        in_b       = W'($urandom);
        in_bipolar = 1'($urandom);
    endtask

    task automatic do_run(input int a, input int b, input bit bip, input int hold);
        int nbits, ones, cyc, exp, held;
        exp = model(a, b, bip);
        chk("accept_ready", in_ready, 1);
        offer(a, b, bip);
        nbits = 0; ones = 0; cyc = 0;
        while (!res_valid && cyc < N + 20) begin
            if (bit_valid) begin
                nbits++;
                ones += int'(bit_out);
            end
            cyc++;
            @(negedge clk);
        end
        chk("res_valid_seen", res_valid, 1);
        chk("run_length", nbits, N);
        chk("popcount", ones, exp);
        chk("res_count", res_count, exp);
        chk("done_in_ready", in_ready, 0);
        held = int'(res_count);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_count", res_count, held);
            chk("hold_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk_idle("after_take");
    endtask

    // Start a run and stop at the negedge of RUN cycle k (1-based).
    task automatic run_to(input int a, input int b, input bit bip, input int k);
        offer(a, b, bip);
        for (int i = 1; i < k; i++) @(negedge clk);
        chk("mid_bit_valid", bit_valid, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_bipolar = 1'b0;
        abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        do_run(5, 3, 1'b0, 0);
        do_run(8, 8, 1'b1, 0);
        do_run(0, 0, 1'b1, 0);
        do_run(0, 15, 1'b0, 0);
        do_run(15, 15, 1'b0, 0);
        do_run(7, 9, 1'b0, 10);
        do_run(12, 3, 1'b1, 0);

        // abort at RUN cycle 100
        run_to(9, 11, 1'b0, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_res", res_valid, 0);
        end
        do_run(5, 3, 1'b0, 0);

        // abort ignored while a result is held
        offer(6, 6, 1'b0);
        repeat (N) @(negedge clk);
        chk("held_valid", res_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_done_valid", res_valid, 1);
        chk("abort_in_done_count", res_count, model(6, 6, 1'b0));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk_idle("abort_in_done_take");

        // rst at RUN cycle 37
        run_to(10, 13, 1'b1, 37);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_mid_run");

        // abort on the final RUN cycle wins over completion
        run_to(4, 4, 1'b0, N);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_last");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_last_no_res", res_valid, 0);
        end

        for (int i = 0; i < 8; i++) begin
            do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
